// File: rtl/seq_mul.sv
// Multi-cycle unsigned shift-add multiplier with valid/ready handshakes on both sides.
// One partial product per clock; the result is held until the consumer takes it.
module seq_mul #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] prod,
    output logic                  ovf
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [PW-1:0]         acc_q, acc_d, acc_step;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        // The full-width accumulator cannot carry out: a*b always fits in PW bits.
        acc_step    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{DATA_WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    state_d     = DONE;
                    prod_d      = acc_step[DATA_WIDTH-1:0];
                    ovf_d       = |acc_step[PW-1:DATA_WIDTH];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign prod      = prod_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed cases plus randomized operands and stalls,
// checked against plain a*b arithmetic.
module tb_seq_mul;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] prod;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    seq_mul #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a_i), .b(b_i),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // One full transaction: accept, optionally poke the busy block, stall, then drain.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input bit poke, input string tag);
        logic [2*W-1:0] full;
        logic [W-1:0]   exp_p;
        logic           exp_o;
        int             n;
        int             lat;
        full  = 16'(a) * 16'(b);
        exp_p = full[W-1:0];
        exp_o = (full[2*W-1:W] != 0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL %s wait_in_ready: in_ready=%b required 1", tag, in_ready);
        end
        a_i = a; b_i = b; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s accept: in_ready=%b required 0", tag, in_ready);
        end
        if (!poke) in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (poke) begin
                a_i = W'($urandom); b_i = W'($urandom);
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_in_ready: in_ready=%b required 0", tag, in_ready);
                end
            end
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != W) begin
            failures++;
            $display("FAIL %s latency: edges=%0d required %0d", tag, lat, W);
        end
        checks++;
        if (prod !== exp_p || ovf !== exp_o) begin
            failures++;
            $display("FAIL %s result a=%0d b=%0d: prod=%0d ovf=%b required prod=%0d ovf=%b",
                     tag, a, b, prod, ovf, exp_p, exp_o);
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || prod !== exp_p || ovf !== exp_o || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s stall%0d: out_valid=%b prod=%0d ovf=%b in_ready=%b required 1/%0d/%b/0",
                         tag, i, out_valid, prod, ovf, in_ready, exp_p, exp_o);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        // If poke left in_valid high through the drain edge, it must not have been accepted.
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s drain: out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s no_accept_on_drain: in_ready=%b required 1", tag, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || prod !== '0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b prod=%0d ovf=%b required 1/0/0/0",
                     in_ready, out_valid, prod, ovf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        run_op(8'd12, 8'd11, 0, 1'b0, "basic");
    endtask

    task automatic test_overflow();
        run_op(8'd255, 8'd255, 0, 1'b0, "ovf_ff");
        run_op(8'd16, 8'd16, 0, 1'b0, "ovf_16");
    endtask

    task automatic test_zero();
        run_op(8'd0, 8'd200, 0, 1'b0, "zero_a");
        run_op(8'd77, 8'd0, 0, 1'b0, "zero_b");
    endtask

    task automatic test_backpressure();
        run_op(8'd5, 8'd9, 5, 1'b0, "backpressure");
    endtask

    task automatic test_busy();
        run_op(8'd7, 8'd6, 2, 1'b1, "busy");
    endtask

    task automatic test_reset_mid();
        // Abandon in CALC at cnt=4.
        a_i = 8'd100; b_i = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0 || prod !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_calc: out_valid=%b prod=%0d ovf=%b in_ready=%b required 0/0/0/1",
                     out_valid, prod, ovf, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        // Abandon in DONE with a nonzero result held.
        a_i = 8'd200; b_i = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (W + 1) begin @(posedge clk); #1; end
        rst_n = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0 || prod !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_done: out_valid=%b prod=%0d ovf=%b in_ready=%b required 0/0/0/1",
                     out_valid, prod, ovf, in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd2, 8'd3, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++)
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), k[2], "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero();
        test_backpressure();
        test_busy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Multi-cycle unsigned shift-add multiplier. It is the inverse-operation companion to the combinational divider in the datapath component library.
- Trades the single-cycle array multiplier for DATA_WIDTH cycles of latency and one adder.
- Sits between HLSM-generated control and the register file. Operands enter and the product leaves through valid/ready handshakes.

Parameters:
- DATA_WIDTH, 8, operand and product width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  DATA_WIDTH  multiplicand, unsigned
- b  input  DATA_WIDTH  multiplier, unsigned
- out_valid  output  1  prod/ovf valid
- out_ready  input  1  consumer accepts result
- prod  output  DATA_WIDTH  low DATA_WIDTH bits of a*b
- ovf  output  1  1 when upper DATA_WIDTH bits of a*b are nonzero

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, accumulator=0, prod=0, ovf=0, out_valid=0. in_ready=1 while in reset and after release.
- Internal registers:
  - mcand: 2*DATA_WIDTH bits, loaded with zero-extended a.
  - mplier: DATA_WIDTH bits, loaded with b.
  - acc: 2*DATA_WIDTH bits.
  - cnt: clog2(DATA_WIDTH+1) bits.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE), decoded combinationally from registered state.
- out_valid = (state==DONE), registered.
- IDLE:
  - On an edge with in_valid=1: load mcand<=a, mplier<=b, acc<=0, cnt<=0, go to CALC.
  - a and b are sampled only at this edge. Later changes to a/b are ignored.
- CALC, one step per edge:
  - If mplier[0]=1, acc<=acc+mcand (2*DATA_WIDTH-bit add, no carry out possible).
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - On the edge where cnt==DATA_WIDTH-1: perform the last step, go to DONE. Register prod<=final acc[DATA_WIDTH-1:0] and ovf<=|final acc[2*DATA_WIDTH-1:DATA_WIDTH] (use the post-add value).
  - No early termination: exactly DATA_WIDTH CALC edges for every operand pair, including a=0 or b=0.
- Latency: acceptance edge E0; out_valid rises after edge E(DATA_WIDTH). For DATA_WIDTH=8, out_valid is high in the cycle following the 8th edge after acceptance.
- DONE:
  - prod, ovf and out_valid hold stable until an edge with out_ready=1, then go to IDLE. out_valid drops and in_ready rises in that next cycle.
  - Throughput is at most one result per DATA_WIDTH+2 cycles; there is no overlap of operations.
- Outside DONE:
  - out_ready is ignored.
  - in_valid is ignored in CALC and DONE; no operand is queued.
- prod/ovf keep their last values after leaving DONE. They are only meaningful while out_valid=1.
- Reset mid-operation (CALC or DONE): the operation is abandoned and the result discarded. All outputs return to reset values immediately (asynchronously). in_ready=1 once rst_n releases.
- Simultaneous in_valid and out_ready in DONE: the result is consumed; the operand is not accepted (in_ready=0 that cycle).

Test Plan:
- Basic multiply: DATA_WIDTH=8, a=12, b=11, out_ready=1.
  -> out_valid after exactly 8 edges post-accept; prod=132 (0x84), ovf=0; in_ready=1 one cycle later.
- Overflow: a=255, b=255.
  -> product 0xFE01: prod=0x01, ovf=1. Also a=16, b=16 -> prod=0x00, ovf=1.
- Zero operands: a=0, b=200, then a=77, b=0.
  -> both produce prod=0, ovf=0, still with full 8-cycle latency.
- Backpressure: a=5, b=9, out_ready=0 for 5 cycles after out_valid.
  -> prod=45 and out_valid held stable all 5 cycles; in_ready stays 0; completes on the first out_ready=1 edge.
- Busy rejection: while in CALC, drive in_valid=1 with a=3, b=3 and change a/b every cycle.
  -> result reflects only the originally accepted operands (e.g. 7*6=42); the second request is not accepted until in_ready returns.
- Reset mid-CALC: assert rst_n=0 at cnt=4 of a=100, b=3.
  -> out_valid=0, prod=0, ovf=0 immediately; after release in_ready=1; next request a=2, b=3 yields prod=6.
